axi_mem_responder: RTL



---
 rtl/axi_common_pkg.sv | 22 ++
 rtl/axi_channel.sv | 86 ++++++++
 rtl/axi_burst_addr_gen.sv | 44 ++++
 rtl/axi_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_common_pkg.sv
// Shared AXI4 encodings and helpers used by the memory responder and its address generator.
package axi_common_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_channel.sv
// AXI4 channel bundle; widths are parameters so endpoints can size themselves via $bits.
interface axi_channel #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned USER_W = 1
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;
    logic [USER_W-1:0]   ar_user;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED/INCR/WRAP plus a burst-legality flag.
module axi_burst_addr_gen
    import axi_common_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              burst_legal
);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_W'(1) << size;
        incr_addr = addr + step;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr   = addr;
        burst_legal = 1'b0;
        case (burst)
            FIXED: begin
                next_addr   = addr;
                burst_legal = 1'b1;
            end
            INCR: begin
                next_addr   = incr_addr;
                burst_legal = 1'b1;
            end
            WRAP: begin
                next_addr   = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                burst_legal = wrap_len_legal(len);
            end
            default: begin
                next_addr   = addr;
                burst_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate serving a word memory with independent single-outstanding read/write engines.
// Define AXI_MEM_RESPONDER_ASSERT_EN to compile initiator-side protocol assertions.
module axi_mem_responder
    import axi_common_pkg::*;
#(
    parameter int unsigned     MEM_DEPTH = 1024,
    parameter longint unsigned BASE_ADDR = 0
) (
    input logic       clk,
    input logic       rstn,
    axi_channel.slave master
);
    localparam int unsigned     DW       = $bits(master.w_data);
    localparam int unsigned     AW       = $bits(master.aw_addr);
    localparam int unsigned     IW       = $bits(master.aw_id);
    localparam int unsigned     NB       = DW / 8;
    localparam int unsigned     OFF_W    = $clog2(NB);
    localparam int unsigned     IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [2:0]      MAX_SIZE = 3'(OFF_W);
    localparam longint unsigned SPAN     = 64'(MEM_DEPTH) * 64'(NB);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic in_range(input logic [AW-1:0] a);
        logic [63:0] a64;
        a64 = 64'(a);
        return (a64 >= BASE_ADDR) && ((a64 - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        logic [63:0] off;
        off = 64'(a) - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];

    // Write engine state
    logic [1:0]    wr_state_q;
    logic          aw_ready_q, w_ready_q, b_valid_q, wr_err_q;
    logic [1:0]    b_resp_q;
    logic [IW-1:0] b_id_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_len_q, wr_cnt_q;
    logic [2:0]    wr_size_q;
    logic [1:0]    wr_burst_q;

    logic [AW-1:0]    wr_next;
    logic             wr_burst_ok, wr_beat_ok, wr_last_beat, w_hs, beat_err, mem_we;
    logic [IDX_W-1:0] wr_idx;

    axi_burst_addr_gen #(.ADDR_W(AW)) u_wr_gen (
        .addr        (wr_addr_q),
        .len         (wr_len_q),
        .size        (wr_size_q),
        .burst       (wr_burst_q),
        .next_addr   (wr_next),
        .burst_legal (wr_burst_ok)
    );

    always_comb begin
        w_hs         = master.w_valid && w_ready_q;
        wr_beat_ok   = wr_burst_ok && (wr_size_q <= MAX_SIZE) && in_range(wr_addr_q);
        wr_last_beat = (wr_cnt_q == wr_len_q);
        // w_last must land exactly on the final counted beat
        beat_err     = !wr_beat_ok || (master.w_last != wr_last_beat);
        mem_we       = w_hs && wr_beat_ok;
        wr_idx       = word_idx(wr_addr_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= OKAY;
            b_id_q     <= '0;
            wr_err_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (master.aw_valid && aw_ready_q) begin
                        wr_addr_q  <= master.aw_addr;
                        wr_len_q   <= master.aw_len;
                        wr_size_q  <= master.aw_size;
                        wr_burst_q <= master.aw_burst;
                        b_id_q     <= master.aw_id;
                        wr_cnt_q   <= '0;
                        wr_err_q   <= 1'b0;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        wr_state_q <= W_DATA;
                    end else begin
                        aw_ready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_addr_q <= wr_next;
                        wr_cnt_q  <= wr_cnt_q + 8'd1;
                        wr_err_q  <= wr_err_q || beat_err;
                        if (wr_last_beat) begin
                            w_ready_q  <= 1'b0;
                            b_valid_q  <= 1'b1;
                            b_resp_q   <= (wr_err_q || beat_err) ? SLVERR : OKAY;
                            wr_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (master.b_ready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (master.w_strb[i]) mem[wr_idx][8*i +: 8] <= master.w_data[8*i +: 8];
            end
        end
    end

    // Read engine state
    logic [0:0]    rd_state_q;
    logic          ar_ready_q, r_valid_q, r_last_q;
    logic [DW-1:0] r_data_q;
    logic [1:0]    r_resp_q;
    logic [IW-1:0] r_id_q;
    logic [AW-1:0] rd_addr_q;
    logic [7:0]    rd_len_q, rd_cnt_q;
    logic [2:0]    rd_size_q;
    logic [1:0]    rd_burst_q;

    logic             rd_idle, rd_burst_ok, load_ok;
    logic [AW-1:0]    rg_addr, rd_next, load_addr;
    logic [7:0]       rg_len;
    logic [2:0]       rg_size;
    logic [1:0]       rg_burst;
    logic [IDX_W-1:0] load_idx;

    // In idle the generator sees the incoming AR so the first beat can be fetched on handshake.
    always_comb begin
        rd_idle   = (rd_state_q == R_IDLE);
        rg_addr   = rd_idle ? master.ar_addr  : rd_addr_q;
        rg_len    = rd_idle ? master.ar_len   : rd_len_q;
        rg_size   = rd_idle ? master.ar_size  : rd_size_q;
        rg_burst  = rd_idle ? master.ar_burst : rd_burst_q;
        load_addr = rd_idle ? master.ar_addr  : rd_next;
        load_ok   = rd_burst_ok && (rg_size <= MAX_SIZE) && in_range(load_addr);
        load_idx  = word_idx(load_addr);
    end

    axi_burst_addr_gen #(.ADDR_W(AW)) u_rd_gen (
        .addr        (rg_addr),
        .len         (rg_len),
        .size        (rg_size),
        .burst       (rg_burst),
        .next_addr   (rd_next),
        .burst_legal (rd_burst_ok)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= OKAY;
            r_id_q     <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (master.ar_valid && ar_ready_q) begin
                        rd_addr_q  <= master.ar_addr;
                        rd_len_q   <= master.ar_len;
                        rd_size_q  <= master.ar_size;
                        rd_burst_q <= master.ar_burst;
                        r_id_q     <= master.ar_id;
                        rd_cnt_q   <= '0;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_data_q   <= load_ok ? mem[load_idx] : '0;
                        r_resp_q   <= load_ok ? OKAY : SLVERR;
                        r_last_q   <= (master.ar_len == 8'd0);
                        rd_state_q <= R_DATA;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (master.r_ready) begin
                        if (r_last_q) begin
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                            ar_ready_q <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_addr_q <= rd_next;
                            rd_cnt_q  <= rd_cnt_q + 8'd1;
                            r_data_q  <= load_ok ? mem[load_idx] : '0;
                            r_resp_q  <= load_ok ? OKAY : SLVERR;
                            r_last_q  <= ((rd_cnt_q + 8'd1) == rd_len_q);
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign master.aw_ready = aw_ready_q;
    assign master.w_ready  = w_ready_q;
    assign master.b_valid  = b_valid_q;
    assign master.b_resp   = b_resp_q;
    assign master.b_id     = b_id_q;
    assign master.b_user   = '0;
    assign master.ar_ready = ar_ready_q;
    assign master.r_valid  = r_valid_q;
    assign master.r_data   = r_data_q;
    assign master.r_resp   = r_resp_q;
    assign master.r_last   = r_last_q;
    assign master.r_id     = r_id_q;
    assign master.r_user   = '0;

    logic unused_sigs;
    assign unused_sigs = ^{master.aw_lock, master.aw_cache, master.aw_prot, master.aw_qos,
                           master.aw_region, master.aw_user, master.w_user, master.ar_lock,
                           master.ar_cache, master.ar_prot, master.ar_qos, master.ar_region,
                           master.ar_user};

`ifdef AXI_MEM_RESPONDER_ASSERT_EN
    aw_stable: assert property (@(posedge clk) disable iff (!rstn)
        master.aw_valid && !master.aw_ready |=> $stable({master.aw_id, master.aw_addr,
            master.aw_len, master.aw_size, master.aw_burst}))
        else $error("aw payload changed while stalled");
    aw_hold: assert property (@(posedge clk) disable iff (!rstn)
        master.aw_valid && !master.aw_ready |=> master.aw_valid)
        else $error("aw_valid dropped before handshake");
    w_stable: assert property (@(posedge clk) disable iff (!rstn)
        master.w_valid && !master.w_ready |=> $stable({master.w_data, master.w_strb,
            master.w_last}))
        else $error("w payload changed while stalled");
    w_hold: assert property (@(posedge clk) disable iff (!rstn)
        master.w_valid && !master.w_ready |=> master.w_valid)
        else $error("w_valid dropped before handshake");
    ar_stable: assert property (@(posedge clk) disable iff (!rstn)
        master.ar_valid && !master.ar_ready |=> $stable({master.ar_id, master.ar_addr,
            master.ar_len, master.ar_size, master.ar_burst}))
        else $error("ar payload changed while stalled");
    ar_hold: assert property (@(posedge clk) disable iff (!rstn)
        master.ar_valid && !master.ar_ready |=> master.ar_valid)
        else $error("ar_valid dropped before handshake");
    valid_known: assert property (@(posedge clk) disable iff (!rstn)
        !$isunknown({master.aw_valid, master.w_valid, master.ar_valid}))
        else $error("X on initiator valid");
`endif

endmodule
